// File: rtl/ft245_sync_rx_fifo_if.sv
// FT2232H FT245-synchronous receive bus plus the packed-word output stream.
// slave  : the receive engine (drives OE#/RD#, word stream, status)
// master : the pins/consumer side (drives data, RXF#, ready)
//   data_i     8            FT2232H data bus
//   rxf_i      1            RXF#, active-low, host data available
//   oe_o       1            OE#, active-low
//   rd_o       1            RD#, active-low
//   m_data_o   8*WORD_BYTES packed output word, first byte in [7:0]
//   m_valid_o  1            word valid
//   m_ready_i  1            consumer ready
//   level_o    AW+1         bytes held in the byte FIFO
//   byte_cnt_o 32           bytes captured since reset
interface ft245_sync_rx_fifo_if #(
  parameter int DEPTH      = 16,
  parameter int WORD_BYTES = 1
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]              data_i;
  logic                    rxf_i;
  logic                    oe_o;
  logic                    rd_o;
  logic [8*WORD_BYTES-1:0] m_data_o;
  logic                    m_valid_o;
  logic                    m_ready_i;
  logic [AW:0]             level_o;
  logic [31:0]             byte_cnt_o;

  modport slave (
    input  data_i, rxf_i, m_ready_i,
    output oe_o, rd_o, m_data_o, m_valid_o, level_o, byte_cnt_o
  );

  modport master (
    output data_i, rxf_i, m_ready_i,
    input  oe_o, rd_o, m_data_o, m_valid_o, level_o, byte_cnt_o
  );
endinterface

// File: rtl/ft245_sync_rx_fifo.sv
// FT245-synchronous receive engine: runs the OE#/RD# read handshake against
// RXF#, buffers host bytes in a DEPTH-byte FIFO and packs them little-endian
// into WORD_BYTES-wide words on a valid/ready stream.
//   clk_i  FT2232H CLKOUT, rising edge
//   rst_i  synchronous reset, active-high
//   bus    ft245_sync_rx_fifo_if.slave (pins, word stream, level, byte count)
module ft245_sync_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int WORD_BYTES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  ft245_sync_rx_fifo_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam int DW = 8 * WORD_BYTES;

  typedef enum logic [1:0] {S_IDLE, S_OE_WAIT, S_READ} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_oe_n, r_rd_n;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]   r_level, w_level_nxt;
  logic [31:0]     r_byte_cnt;
  logic [DW-1:0]   r_pack_data;
  logic [CW-1:0]   r_pack_cnt, w_pack_base;
  logic            w_push, w_pop, w_full_word, w_accept;

  // Bus holds a valid byte only while RD# (as registered) and RXF# are both low.
  assign w_push      = !r_rd_n && !bus.rxf_i;
  assign w_full_word = (r_pack_cnt == CW'(WORD_BYTES));
  assign w_accept    = w_full_word && bus.m_ready_i;
  // A full word leaving this edge frees the packer for a fresh first byte.
  assign w_pop       = (r_level != '0) && (!w_full_word || bus.m_ready_i);
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
  assign w_pack_base = w_accept ? '0 : r_pack_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (!bus.rxf_i && (r_level < LW'(DEPTH - 1))) w_state_nxt = S_OE_WAIT;
      S_OE_WAIT: w_state_nxt = bus.rxf_i ? S_IDLE : S_READ;
      // Leave before the FIFO could overflow: level_next already counts this edge.
      S_READ:    if (bus.rxf_i || (w_level_nxt >= LW'(DEPTH))) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // OE#/RD# registered from next state: no combinational path from RXF#.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_oe_n  <= 1'b1;
      r_rd_n  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_oe_n  <= (w_state_nxt == S_IDLE);
      r_rd_n  <= (w_state_nxt != S_READ);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_byte_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_byte_cnt <= r_byte_cnt + 32'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pack_data <= '0;
      r_pack_cnt  <= '0;
    end else if (w_pop) begin
      for (int b = 0; b < WORD_BYTES; b++)
        if (CW'(b) == w_pack_base) r_pack_data[8*b +: 8] <= r_mem[r_rd_ptr];
      r_pack_cnt <= w_pack_base + CW'(1);
    end else if (w_accept) begin
      r_pack_cnt <= '0;
    end
  end

  assign bus.oe_o       = r_oe_n;
  assign bus.rd_o       = r_rd_n;
  assign bus.m_data_o   = r_pack_data;
  assign bus.m_valid_o  = w_full_word;
  assign bus.level_o    = r_level;
  assign bus.byte_cnt_o = r_byte_cnt;
endmodule

// File: tb/tb_ft245_sync_rx_fifo.sv
// Bench for ft245_sync_rx_fifo: an FT2232H-side host model hands out bytes
// (advancing on edges with RD#=0 and RXF#=0); every accepted word is compared
// against the host byte order packed little-endian.
module tb_ft245_sync_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ft245_sync_rx_fifo_if #(.DEPTH(16), .WORD_BYTES(1)) if1 ();
  ft245_sync_rx_fifo_if #(.DEPTH(16), .WORD_BYTES(4)) if4 ();

  ft245_sync_rx_fifo #(.DEPTH(16), .WORD_BYTES(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
  ft245_sync_rx_fifo #(.DEPTH(16), .WORD_BYTES(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(if4));

  int cur = 0;
  int errors = 0, checks = 0;
  int words, caps, oe_falls, gap_cnt, gap_after;
  bit rnd_ready, rnd_gap;
  logic rdy_fixed, cur_rxf, cur_rdy;
  logic [31:0] mcnt;
  logic [7:0] hostq[$];
  logic [7:0] expq[$];

  logic s_oe, s_rd, s_valid;
  logic [31:0] s_data, s_cnt;
  logic [4:0] s_level;
  assign s_oe    = (cur == 1) ? if4.oe_o : if1.oe_o;
  assign s_rd    = (cur == 1) ? if4.rd_o : if1.rd_o;
  assign s_valid = (cur == 1) ? if4.m_valid_o : if1.m_valid_o;
  assign s_data  = (cur == 1) ? if4.m_data_o : {24'h0, if1.m_data_o};
  assign s_cnt   = (cur == 1) ? if4.byte_cnt_o : if1.byte_cnt_o;
  assign s_level = (cur == 1) ? if4.level_o : if1.level_o;

  function automatic int wb();
    return (cur == 1) ? 4 : 1;
  endfunction

  task automatic clear_model();
    hostq.delete(); expq.delete();
    mcnt = 0; words = 0; caps = 0; oe_falls = 0;
    gap_cnt = 0; gap_after = -1; rnd_ready = 0; rnd_gap = 0; rdy_fixed = 1'b0;
  endtask

  // Host side: RXF# low while bytes remain and no gap; junk on the bus otherwise.
  task automatic drive();
    logic rx;
    logic [7:0] d;
    if (gap_after >= 0 && caps == gap_after) begin gap_cnt = 3; gap_after = -1; end
    if (rnd_gap && gap_cnt == 0 && $urandom_range(0, 15) == 0) gap_cnt = $urandom_range(1, 3);
    rx = (hostq.size() == 0) || (gap_cnt > 0);
    if (gap_cnt > 0) gap_cnt--;
    if (hostq.size() == 0) d = 8'($urandom);
    else if (rx) d = ~hostq[0];
    else d = hostq[0];
    cur_rdy = rnd_ready ? 1'($urandom_range(0, 1)) : rdy_fixed;
    cur_rxf = rx;
    if (cur == 1) begin
      if4.rxf_i = rx; if4.data_i = d; if4.m_ready_i = cur_rdy;
      if1.rxf_i = 1'b1; if1.data_i = 8'h00; if1.m_ready_i = 1'b0;
    end else begin
      if1.rxf_i = rx; if1.data_i = d; if1.m_ready_i = cur_rdy;
      if4.rxf_i = 1'b1; if4.data_i = 8'h00; if4.m_ready_i = 1'b0;
    end
  endtask

  task automatic step();
    logic p_rd, p_oe, p_rxf, p_v, p_rdy, p_rst;
    logic [31:0] p_d, e;
    p_rd = s_rd; p_oe = s_oe; p_rxf = cur_rxf; p_v = s_valid; p_rdy = cur_rdy;
    p_d = s_data; p_rst = rst;
    @(posedge clk); #1;
    if (!p_rst) begin
      if (!p_rd && !p_rxf) begin
        expq.push_back(hostq.pop_front()); mcnt++; caps++;
      end
      if (p_oe && !s_oe) oe_falls++;
      if (p_v && p_rdy) begin
        checks++;
        if (expq.size() < wb()) begin
          errors++; $display("FAIL word_extra: got %h, no complete word expected", p_d);
        end else begin
          e = 0;
          for (int i = 0; i < wb(); i++) e[8*i +: 8] = expq.pop_front();
          if (p_d !== e) begin errors++; $display("FAIL word: got %h want %h", p_d, e); end
        end
        words++;
      end
      if (p_rxf) begin
        checks++;
        if (s_rd !== 1'b1 || s_oe !== 1'b1) begin
          errors++; $display("FAIL rxf_release: oe=%b rd=%b want 1 1", s_oe, s_rd);
        end
      end
      if (p_rd && !s_rd) begin
        checks++;
        if (p_oe !== 1'b0) begin errors++; $display("FAIL oe_lead: prior oe=%b want 0", p_oe); end
      end
      if (p_v && !p_rdy) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== p_d) begin
          errors++; $display("FAIL hold: valid=%b data=%h want 1 %h", s_valid, s_data, p_d);
        end
      end
    end
    drive();
  endtask

  task automatic drain(int budget, string name);
    int n = 0;
    while (!(hostq.size() == 0 && expq.size() < wb()) && n < budget) begin step(); n++; end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL %s_timeout: %0d cycles, want < %0d", name, n, budget); end
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; drive();
    repeat (3) step();
    rst = 1'b0; step();
    for (int k = 0; k < 2; k++) begin
      cur = k; #1;
      checks++;
      if ({s_oe, s_rd, s_valid} !== 3'b110) begin
        errors++; $display("FAIL reset_ctl[%0d]: oe,rd,valid=%b want 110", k, {s_oe, s_rd, s_valid});
      end
      checks++;
      if (s_data !== 32'h0 || s_level !== 5'd0 || s_cnt !== 32'h0) begin
        errors++; $display("FAIL reset_state[%0d]: data=%h level=%0d cnt=%0d want 0", k, s_data, s_level, s_cnt);
      end
    end
    cur = 0; #1; drive();
  endtask

  task automatic test_burst();
    words = 0; oe_falls = 0; rdy_fixed = 1'b1;
    for (int i = 1; i <= 8; i++) hostq.push_back(8'(i));
    drive();
    step();
    checks++;
    if (s_oe !== 1'b0 || s_rd !== 1'b1) begin errors++; $display("FAIL lat_oe: oe=%b rd=%b want 0 1", s_oe, s_rd); end
    step();
    checks++;
    if (s_oe !== 1'b0 || s_rd !== 1'b0) begin errors++; $display("FAIL lat_rd: oe=%b rd=%b want 0 0", s_oe, s_rd); end
    step();
    checks++;
    if (s_level !== 5'd1 || s_cnt !== 32'd1) begin
      errors++; $display("FAIL first_capture: level=%0d cnt=%0d want 1 1", s_level, s_cnt);
    end
    step();
    checks++;
    if (s_valid !== 1'b1) begin errors++; $display("FAIL valid_lat: valid=%b want 1", s_valid); end
    drain(40, "burst");
    checks++;
    if (words != 8) begin errors++; $display("FAIL burst_words: got %0d want 8", words); end
    checks++;
    if (s_cnt !== 32'd8 || s_rd !== 1'b1 || s_level !== 5'd0) begin
      errors++; $display("FAIL burst_end: cnt=%0d rd=%b level=%0d want 8 1 0", s_cnt, s_rd, s_level);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int w0 = words;
    rdy_fixed = 1'b0;
    repeat (24) hostq.push_back(8'($urandom));
    drive();
    while (s_level !== 5'd16 && n < 80) begin step(); n++; end
    checks++;
    if (s_level !== 5'd16) begin errors++; $display("FAIL bp_fill: level=%0d want 16", s_level); end
    checks++;
    if (s_rd !== 1'b1 || s_oe !== 1'b1 || s_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stop: oe=%b rd=%b valid=%b want 1 1 1", s_oe, s_rd, s_valid);
    end
    repeat (4) step();
    checks++;
    if (s_cnt !== mcnt || s_cnt !== 32'd25 || s_rd !== 1'b1) begin
      errors++; $display("FAIL bp_hold: cnt=%0d rd=%b want %0d 1", s_cnt, s_rd, mcnt);
    end
    rdy_fixed = 1'b1; drive();
    drain(200, "bp");
    checks++;
    if (words - w0 != 24 || s_cnt !== mcnt || s_level !== 5'd0) begin
      errors++; $display("FAIL bp_resume: words=%0d cnt=%0d level=%0d want 24 %0d 0", words - w0, s_cnt, s_level, mcnt);
    end
  endtask

  task automatic test_rxf_gap();
    int w0 = words;
    caps = 0; oe_falls = 0; gap_after = 4; rdy_fixed = 1'b1;
    for (int i = 0; i < 12; i++) hostq.push_back(8'h30 + 8'(i));
    drive();
    drain(100, "gap");
    checks++;
    if (words - w0 != 12 || s_cnt !== mcnt) begin
      errors++; $display("FAIL gap_words: words=%0d cnt=%0d want 12 %0d", words - w0, s_cnt, mcnt);
    end
    checks++;
    if (oe_falls != 2) begin errors++; $display("FAIL gap_reentry: oe falls=%0d want 2", oe_falls); end
  endtask

  task automatic test_random(int nbytes);
    rnd_ready = 1; rnd_gap = 1;
    repeat (nbytes) hostq.push_back(8'($urandom));
    drive();
    drain(4000, "random");
    rnd_ready = 0; rnd_gap = 0; rdy_fixed = 1'b1; drive();
    repeat (2) step();
    checks++;
    if (s_cnt !== mcnt || s_level !== 5'd0 || s_valid !== 1'b0) begin
      errors++; $display("FAIL random_end: cnt=%0d level=%0d valid=%b want %0d 0 0", s_cnt, s_level, s_valid, mcnt);
    end
  endtask

  task automatic test_wrap();
    force u_dut1.r_byte_cnt = 32'hFFFF_FFFF;
    step();
    release u_dut1.r_byte_cnt;
    step();
    checks++;
    if (s_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: cnt=%h want ffffffff", s_cnt); end
    mcnt = 32'hFFFF_FFFF;
    hostq.push_back(8'h5A); hostq.push_back(8'hC3);
    rdy_fixed = 1'b1; drive();
    drain(40, "wrap");
    checks++;
    if (s_cnt !== 32'h0000_0001 || mcnt !== 32'h0000_0001) begin
      errors++; $display("FAIL wrap: cnt=%h want 00000001", s_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    rdy_fixed = 1'b0;
    repeat (10) hostq.push_back(8'($urandom));
    drive();
    while (s_rd !== 1'b0 && n < 10) begin step(); n++; end
    repeat (3) step();
    checks++;
    if (s_rd !== 1'b0 || s_valid !== 1'b1) begin
      errors++; $display("FAIL midburst_setup: rd=%b valid=%b want 0 1", s_rd, s_valid);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({s_oe, s_rd, s_valid} !== 3'b110 || s_level !== 5'd0 || s_cnt !== 32'h0) begin
      errors++; $display("FAIL midburst_reset: oe,rd,valid=%b level=%0d cnt=%0d want 110 0 0", {s_oe, s_rd, s_valid}, s_level, s_cnt);
    end
    clear_model();
    drive();
    rst = 1'b0;
    step();
  endtask

  task automatic test_packing();
    rdy_fixed = 1'b1; words = 0;
    hostq.push_back(8'hA0); hostq.push_back(8'hA1); hostq.push_back(8'hA2);
    hostq.push_back(8'hA3); hostq.push_back(8'hB0);
    drive();
    drain(40, "pack");
    checks++;
    if (words != 1 || s_valid !== 1'b0) begin
      errors++; $display("FAIL pack_words: words=%0d valid=%b want 1 0", words, s_valid);
    end
    checks++;
    if (s_cnt !== 32'd5 || s_level !== 5'd0) begin
      errors++; $display("FAIL pack_state: cnt=%0d level=%0d want 5 0", s_cnt, s_level);
    end
  endtask

  initial begin
    clear_model();
    drive();
    test_reset();
    test_burst();
    test_backpressure();
    test_rxf_gap();
    test_random(150);
    test_wrap();
    test_reset_mid_burst();
    cur = 1; #1;
    clear_model();
    rst = 1'b1; drive();
    repeat (2) step();
    rst = 1'b0; step();
    test_packing();
    test_random(120);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
